hazard_detection_unit: RTL and testbench
========================================

HAZARD_DETECTION_UNIT -- requirements
Module: hazard_detection_unit

Interface
REQ-001 clk  input  1  pipeline clock; all state updates on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 rs1use_ID, rs2_use_ID  input  1 each  decoded ID-stage source-use flags.
REQ-004 hazard_optype_ID  input  2  ID op class: 00 none/bubble, 01 ALU, 10 LOAD, 11 STORE.
REQ-005 rs1_ID, rs2_ID, rd_ID  input  5 each  ID-stage register addresses.
REQ-006 Branch_ID  input  1  taken branch/jump resolved in ID.
REQ-007 forward_ctrl_A, forward_ctrl_B  output  2 each  ID operand source: 00 regfile, 01 EX ALU result, 10 MEM ALU result, 11 MEM load data.
REQ-008 forward_ctrl_ls  output  1  store data in EX replaced by load data arriving from MEM.
REQ-009 PC_EN_IF, reg_FD_EN  output  1 each  PC and IF/ID register enables.
REQ-010 reg_FD_flush, reg_DE_flush  output  1 each  IF/ID and ID/EX bubble insertion.

Function
REQ-011 Shadow pipeline SHALL hold: EX {optype, rd, rs2}, MEM {optype, rd}.
REQ-012 Each edge: MEM <= EX; EX <= ID fields, or EX optype <= 00 when load_stall is 1.
REQ-013 Match on an address SHALL require address != 0 and the matching stage optype in {01, 10}.
REQ-014 load_stall SHALL be 1 when EX optype = 10, rd_EX matches, and either rs1use_ID with rs1_ID, or rs2_use_ID with rs2_ID while ID optype != 11.
REQ-015 ID optype = 11 with EX load on rs2 SHALL NOT stall; store-data forwarding occurs one cycle later.
REQ-016 forward_ctrl_A (rs1/rs1use_ID) priority: EX ALU match -> 01; else MEM ALU match -> 10; else MEM load match -> 11; else 00.
REQ-017 forward_ctrl_B uses the same rule with rs2_ID and rs2_use_ID.
REQ-018 forward_ctrl_ls = 1 when EX optype = 11, MEM optype = 10, rd_MEM = rs2_EX, rs2_EX != 0.
REQ-019 WB stage needs no forwarding: the register file writes in the first half-cycle.
REQ-020 PC_EN_IF = reg_FD_EN = ~load_stall; reg_DE_flush = load_stall.
REQ-021 reg_FD_flush = Branch_ID & ~load_stall; Branch_ID with stale operands SHALL NOT flush.
REQ-022 All outputs SHALL be combinational from ID inputs and shadow state, with zero-cycle latency.
REQ-023 Back-to-back loads each stall at most one cycle; stall never persists beyond one cycle per load-use pair.

Reset
REQ-024 rst_n low: all shadow optype fields SHALL be 00 and rd/rs2 fields 0, immediately and asynchronously.
REQ-025 During and just after reset: forward_ctrl_* = 0, PC_EN_IF = reg_FD_EN = 1, flush outputs = 0.
REQ-026 Reset asserted mid-stall SHALL clear the stall in the same cycle.

Configuration
REQ-027 Macro HAZARD_FORWARD_EN defined: forwarding behaves per REQ-016 to REQ-018.
REQ-028 HAZARD_FORWARD_EN undefined: forward_ctrl_* tie to 0, and the unit stalls (same outputs as load_stall) on any REQ-013 match in EX or MEM.
REQ-029 HAZARD_FORWARD_EN undefined: a store's rs2 counts as a normal use.

Verification
REQ-030 addi x5 in EX, ID add x6,x5,x7 -> forward_ctrl_A = 01, forward_ctrl_B = 00, no stall.
REQ-031 lw x5 in EX, ID add x6,x5,x5 -> 1 cycle with PC_EN_IF = 0 and reg_DE_flush = 1, then forward_ctrl_A = forward_ctrl_B = 11.
REQ-032 lw x5 in EX, ID sw x5,0(x8) -> no stall; next cycle forward_ctrl_ls = 1.
REQ-033 lw x5 in EX, ID beq x5,x0 with Branch_ID = 1 -> reg_FD_flush = 0 during the stall cycle, then 1.
REQ-034 rd = x0 in EX and MEM, ID reads x0 -> all forward_ctrl = 00, no stall.
REQ-035 Assert rst_n low during a load stall -> PC_EN_IF returns to 1 with no clock edge; without HAZARD_FORWARD_EN, ALU RAW at distance 1 -> 2 stall cycles.

Source files
------------

// File: rtl/hazard_detection_unit.sv
// Load-use stall, operand forwarding and flush control for a five-stage pipeline.
// Define HAZARD_FORWARD_EN to enable forwarding; otherwise every RAW hazard in EX/MEM stalls.
module hazard_detection_unit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rs1use_ID,
    input  logic       rs2_use_ID,
    input  logic [1:0] hazard_optype_ID,
    input  logic [4:0] rs1_ID,
    input  logic [4:0] rs2_ID,
    input  logic [4:0] rd_ID,
    input  logic       Branch_ID,
    output logic [1:0] forward_ctrl_A,
    output logic [1:0] forward_ctrl_B,
    output logic       forward_ctrl_ls,
    output logic       PC_EN_IF,
    output logic       reg_FD_EN,
    output logic       reg_FD_flush,
    output logic       reg_DE_flush
);

    localparam logic [1:0] OP_NONE  = 2'b00;
    localparam logic [1:0] OP_ALU   = 2'b01;
    localparam logic [1:0] OP_LOAD  = 2'b10;
    localparam logic [1:0] OP_STORE = 2'b11;

    // A stage produces a value for rs only if it writes a nonzero register that matches.
    function automatic logic writes_reg(input logic [1:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs);
        return (rs != 5'd0) && (rd == rs) && ((op == OP_ALU) || (op == OP_LOAD));
    endfunction

    logic [1:0] ex_op_r;
    logic [4:0] ex_rd_r;
    logic [1:0] mem_op_r;
    logic [4:0] mem_rd_r;
    logic       stall_s;
    logic [1:0] fwd_a_s;
    logic [1:0] fwd_b_s;
    logic       fwd_ls_s;

`ifdef HAZARD_FORWARD_EN
    logic [4:0] ex_rs2_r;

    function automatic logic [1:0] fwd_sel(input logic use_rs, input logic [4:0] rs,
                                           input logic [1:0] ex_op, input logic [4:0] ex_rd,
                                           input logic [1:0] mem_op, input logic [4:0] mem_rd);
        logic [1:0] sel;
        if (!use_rs) begin
            sel = 2'b00;
        end else if ((ex_op == OP_ALU) && writes_reg(ex_op, ex_rd, rs)) begin
            sel = 2'b01;
        end else if ((mem_op == OP_ALU) && writes_reg(mem_op, mem_rd, rs)) begin
            sel = 2'b10;
        end else if ((mem_op == OP_LOAD) && writes_reg(mem_op, mem_rd, rs)) begin
            sel = 2'b11;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // Store-data register kept for the EX-stage load-to-store forward.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_rs2_r <= 5'd0;
        end else begin
            ex_rs2_r <= rs2_ID;
        end
    end

    // Only a load still in EX forces a stall; a store's data operand waits for MEM forwarding.
    always_comb begin
        stall_s  = 1'b0;
        fwd_a_s  = 2'b00;
        fwd_b_s  = 2'b00;
        fwd_ls_s = 1'b0;
        if (ex_op_r == OP_LOAD) begin
            stall_s = (rs1use_ID && writes_reg(ex_op_r, ex_rd_r, rs1_ID)) ||
                      (rs2_use_ID && (hazard_optype_ID != OP_STORE) &&
                       writes_reg(ex_op_r, ex_rd_r, rs2_ID));
        end else begin
            stall_s = 1'b0;
        end
        fwd_a_s  = fwd_sel(rs1use_ID, rs1_ID, ex_op_r, ex_rd_r, mem_op_r, mem_rd_r);
        fwd_b_s  = fwd_sel(rs2_use_ID, rs2_ID, ex_op_r, ex_rd_r, mem_op_r, mem_rd_r);
        fwd_ls_s = (ex_op_r == OP_STORE) && (mem_op_r == OP_LOAD) &&
                   (mem_rd_r == ex_rs2_r) && (ex_rs2_r != 5'd0);
    end
`else
    // Without forwarding any pending writer in EX or MEM stalls the consumer, stores included.
    always_comb begin
        stall_s  = 1'b0;
        fwd_a_s  = 2'b00;
        fwd_b_s  = 2'b00;
        fwd_ls_s = 1'b0;
        if (rs1use_ID && (writes_reg(ex_op_r, ex_rd_r, rs1_ID) ||
                          writes_reg(mem_op_r, mem_rd_r, rs1_ID))) begin
            stall_s = 1'b1;
        end else if (rs2_use_ID && (writes_reg(ex_op_r, ex_rd_r, rs2_ID) ||
                                    writes_reg(mem_op_r, mem_rd_r, rs2_ID))) begin
            stall_s = 1'b1;
        end else begin
            stall_s = 1'b0;
        end
    end
`endif

    // Shadow pipeline: a stalled ID instruction enters EX as a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_op_r  <= OP_NONE;
            ex_rd_r  <= 5'd0;
            mem_op_r <= OP_NONE;
            mem_rd_r <= 5'd0;
        end else begin
            mem_op_r <= ex_op_r;
            mem_rd_r <= ex_rd_r;
            ex_op_r  <= stall_s ? OP_NONE : hazard_optype_ID;
            ex_rd_r  <= rd_ID;
        end
    end

    // Branch flush is held off while operands are stale and while in reset.
    always_comb begin
        forward_ctrl_A  = fwd_a_s;
        forward_ctrl_B  = fwd_b_s;
        forward_ctrl_ls = fwd_ls_s;
        PC_EN_IF        = ~stall_s;
        reg_FD_EN       = ~stall_s;
        reg_DE_flush    = stall_s;
        reg_FD_flush    = Branch_ID & ~stall_s & rst_n;
    end

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Randomized and directed checks of hazard_detection_unit against an instruction-level model.
// Expectations follow HAZARD_FORWARD_EN exactly as the DUT is built.
module tb_hazard_detection_unit;

    typedef struct packed {
        logic [1:0] op;
        logic [4:0] rd;
        logic [4:0] rs2;
    } instr_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rs1use_ID, rs2_use_ID, Branch_ID;
    logic [1:0] hazard_optype_ID;
    logic [4:0] rs1_ID, rs2_ID, rd_ID;
    logic [1:0] forward_ctrl_A, forward_ctrl_B;
    logic       forward_ctrl_ls, PC_EN_IF, reg_FD_EN, reg_FD_flush, reg_DE_flush;

    int checks = 0;
    int errors = 0;
    instr_t pipe_q[$];   // [0] = instruction in EX, [1] = instruction in MEM

    hazard_detection_unit dut (
        .clk(clk), .rst_n(rst_n), .rs1use_ID(rs1use_ID), .rs2_use_ID(rs2_use_ID),
        .hazard_optype_ID(hazard_optype_ID), .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .rd_ID(rd_ID),
        .Branch_ID(Branch_ID), .forward_ctrl_A(forward_ctrl_A), .forward_ctrl_B(forward_ctrl_B),
        .forward_ctrl_ls(forward_ctrl_ls), .PC_EN_IF(PC_EN_IF), .reg_FD_EN(reg_FD_EN),
        .reg_FD_flush(reg_FD_flush), .reg_DE_flush(reg_DE_flush)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] observed();
        return {forward_ctrl_A, forward_ctrl_B, forward_ctrl_ls, PC_EN_IF, reg_FD_EN,
                reg_FD_flush, reg_DE_flush};
    endfunction

    function automatic logic writes(input instr_t i, input logic [4:0] r);
        return (r != 5'd0) && (i.rd == r) && ((i.op == 2'd1) || (i.op == 2'd2));
    endfunction

    function automatic logic [1:0] pick(input logic u, input logic [4:0] r,
                                        input instr_t ex, input instr_t mem);
        if (!u) return 2'd0;
        if (ex.op == 2'd1 && writes(ex, r)) return 2'd1;
        if (mem.op == 2'd1 && writes(mem, r)) return 2'd2;
        if (mem.op == 2'd2 && writes(mem, r)) return 2'd3;
        return 2'd0;
    endfunction

    task automatic ref_eval(output logic [1:0] fa, output logic [1:0] fb,
                            output logic fls, output logic stall);
        instr_t ex;
        instr_t mem;
        ex  = pipe_q[0];
        mem = pipe_q[1];
`ifdef HAZARD_FORWARD_EN
        stall = (ex.op == 2'd2) &&
                ((rs1use_ID && writes(ex, rs1_ID)) ||
                 (rs2_use_ID && hazard_optype_ID != 2'd3 && writes(ex, rs2_ID)));
        fa  = pick(rs1use_ID, rs1_ID, ex, mem);
        fb  = pick(rs2_use_ID, rs2_ID, ex, mem);
        fls = (ex.op == 2'd3) && (mem.op == 2'd2) && (mem.rd == ex.rs2) && (ex.rs2 != 5'd0);
`else
        stall = (rs1use_ID && (writes(ex, rs1_ID) || writes(mem, rs1_ID))) ||
                (rs2_use_ID && (writes(ex, rs2_ID) || writes(mem, rs2_ID)));
        fa  = 2'd0;
        fb  = 2'd0;
        fls = 1'b0;
`endif
    endtask

    // Model the coming clock edge: the ID instruction enters EX (as a bubble if stalled).
    task automatic advance();
        logic [1:0] fa, fb;
        logic       fls, stall;
        instr_t     n;
        ref_eval(fa, fb, fls, stall);
        n.op  = stall ? 2'd0 : hazard_optype_ID;
        n.rd  = rd_ID;
        n.rs2 = rs2_ID;
        pipe_q.push_front(n);
        void'(pipe_q.pop_back());
    endtask

    task automatic model_reset();
        pipe_q = {};
        pipe_q.push_back(instr_t'(12'd0));
        pipe_q.push_back(instr_t'(12'd0));
    endtask

    task automatic put_id(input logic [1:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic u1, input logic u2, input logic br);
        @(negedge clk);
        hazard_optype_ID = op; rd_ID = rd; rs1_ID = rs1; rs2_ID = rs2;
        rs1use_ID = u1; rs2_use_ID = u2; Branch_ID = br;
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 2; i++) begin
            put_id(2'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
            advance();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        hazard_optype_ID = 2'd2; rd_ID = 5'd3; rs1_ID = 5'd3; rs2_ID = 5'd3;
        rs1use_ID = 1'b1; rs2_use_ID = 1'b1; Branch_ID = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        checks++;
        if (observed() !== 9'b00_00_0_1_1_0_0) begin
            errors++;
            $display("FAIL reset_outputs got %b want %b", observed(), 9'b00_00_0_1_1_0_0);
        end
        rst_n = 1'b1;
        drain();
    endtask

    task automatic test_alu_forward();
        put_id(2'd1, 5'd5, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0); advance();
        put_id(2'd1, 5'd6, 5'd5, 5'd7, 1'b1, 1'b1, 1'b0);
        checks++;
`ifdef HAZARD_FORWARD_EN
        if ({forward_ctrl_A, forward_ctrl_B, PC_EN_IF, reg_DE_flush} !== 6'b01_00_1_0) begin
            errors++;
            $display("FAIL alu_fwd got A=%b B=%b pc=%b de=%b want A=01 B=00 pc=1 de=0",
                     forward_ctrl_A, forward_ctrl_B, PC_EN_IF, reg_DE_flush);
        end
`else
        if ({PC_EN_IF, reg_DE_flush} !== 2'b01) begin
            errors++;
            $display("FAIL alu_stall1 got pc=%b de=%b want pc=0 de=1", PC_EN_IF, reg_DE_flush);
        end
        advance();
        put_id(2'd1, 5'd6, 5'd5, 5'd7, 1'b1, 1'b1, 1'b0);
        checks++;
        if (PC_EN_IF !== 1'b0) begin
            errors++;
            $display("FAIL alu_stall2 got pc=%b want 0", PC_EN_IF);
        end
        advance();
        put_id(2'd1, 5'd6, 5'd5, 5'd7, 1'b1, 1'b1, 1'b0);
        checks++;
        if ({forward_ctrl_A, PC_EN_IF} !== 3'b00_1) begin
            errors++;
            $display("FAIL alu_release got A=%b pc=%b want A=00 pc=1", forward_ctrl_A, PC_EN_IF);
        end
`endif
        advance();
        drain();
    endtask

    task automatic test_load_use();
        put_id(2'd2, 5'd5, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0); advance();
        put_id(2'd1, 5'd6, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0);
        checks++;
        if ({PC_EN_IF, reg_FD_EN, reg_DE_flush} !== 3'b001) begin
            errors++;
            $display("FAIL load_use_stall got pc=%b fd_en=%b de=%b want 0 0 1",
                     PC_EN_IF, reg_FD_EN, reg_DE_flush);
        end
        advance();
        put_id(2'd1, 5'd6, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0);
        checks++;
`ifdef HAZARD_FORWARD_EN
        if ({forward_ctrl_A, forward_ctrl_B, PC_EN_IF, reg_DE_flush} !== 6'b11_11_1_0) begin
            errors++;
            $display("FAIL load_use_fwd got A=%b B=%b pc=%b de=%b want A=11 B=11 pc=1 de=0",
                     forward_ctrl_A, forward_ctrl_B, PC_EN_IF, reg_DE_flush);
        end
`else
        if (PC_EN_IF !== 1'b0) begin
            errors++;
            $display("FAIL load_use_stall2 got pc=%b want 0", PC_EN_IF);
        end
        advance();
        put_id(2'd1, 5'd6, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0);
        checks++;
        if ({forward_ctrl_A, forward_ctrl_B, PC_EN_IF} !== 5'b00_00_1) begin
            errors++;
            $display("FAIL load_use_release got A=%b B=%b pc=%b want 00 00 1",
                     forward_ctrl_A, forward_ctrl_B, PC_EN_IF);
        end
`endif
        advance();
        drain();
    endtask

    task automatic test_store_data();
        put_id(2'd2, 5'd5, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0); advance();
        put_id(2'd3, 5'd0, 5'd8, 5'd5, 1'b1, 1'b1, 1'b0);
        checks++;
`ifdef HAZARD_FORWARD_EN
        if (PC_EN_IF !== 1'b1) begin
            errors++;
            $display("FAIL store_nostall got pc=%b want 1", PC_EN_IF);
        end
        advance();
        put_id(2'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (forward_ctrl_ls !== 1'b1) begin
            errors++;
            $display("FAIL store_ls got ls=%b want 1", forward_ctrl_ls);
        end
`else
        if (PC_EN_IF !== 1'b0) begin
            errors++;
            $display("FAIL store_stall got pc=%b want 0", PC_EN_IF);
        end
        advance();
        put_id(2'd3, 5'd0, 5'd8, 5'd5, 1'b1, 1'b1, 1'b0);
        advance();
        put_id(2'd3, 5'd0, 5'd8, 5'd5, 1'b1, 1'b1, 1'b0);
        checks++;
        if ({PC_EN_IF, forward_ctrl_ls} !== 2'b10) begin
            errors++;
            $display("FAIL store_release got pc=%b ls=%b want 1 0", PC_EN_IF, forward_ctrl_ls);
        end
`endif
        advance();
        drain();
    endtask

    task automatic test_branch_stall();
        int n_stall;
        put_id(2'd2, 5'd5, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0); advance();
`ifdef HAZARD_FORWARD_EN
        n_stall = 1;
`else
        n_stall = 2;
`endif
        for (int c = 0; c <= n_stall; c++) begin
            put_id(2'd0, 5'd0, 5'd5, 5'd0, 1'b1, 1'b1, 1'b1);
            checks++;
            if (reg_FD_flush !== (c == n_stall)) begin
                errors++;
                $display("FAIL branch_flush cycle %0d got %b want %b", c, reg_FD_flush,
                         (c == n_stall));
            end
            advance();
        end
        drain();
    endtask

    task automatic test_x0();
        put_id(2'd1, 5'd0, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0); advance();
        put_id(2'd2, 5'd0, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0); advance();
        put_id(2'd1, 5'd6, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
        checks++;
        if ({forward_ctrl_A, forward_ctrl_B, PC_EN_IF, reg_DE_flush} !== 6'b00_00_1_0) begin
            errors++;
            $display("FAIL x0_nohazard got A=%b B=%b pc=%b de=%b want 00 00 1 0",
                     forward_ctrl_A, forward_ctrl_B, PC_EN_IF, reg_DE_flush);
        end
        advance();
        drain();
    endtask

    task automatic test_reset_mid_stall();
        put_id(2'd2, 5'd5, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0); advance();
        put_id(2'd1, 5'd6, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1);
        checks++;
        if (PC_EN_IF !== 1'b0) begin
            errors++;
            $display("FAIL midstall_pre got pc=%b want 0", PC_EN_IF);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (observed() !== 9'b00_00_0_1_1_0_0) begin
            errors++;
            $display("FAIL midstall_reset got %b want %b", observed(), 9'b00_00_0_1_1_0_0);
        end
        model_reset();
        #1 rst_n = 1'b1;
        advance();
        drain();
    endtask

    task automatic test_random();
        logic [1:0] fa, fb;
        logic       fls, stall;
        logic [8:0] exp;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            hazard_optype_ID = 2'($urandom_range(3, 0));
            rd_ID      = 5'($urandom_range(3, 0));
            rs1_ID     = 5'($urandom_range(3, 0));
            rs2_ID     = 5'($urandom_range(3, 0));
            rs1use_ID  = 1'($urandom_range(1, 0));
            rs2_use_ID = 1'($urandom_range(1, 0));
            Branch_ID  = ($urandom_range(7, 0) == 0);
            #1;
            ref_eval(fa, fb, fls, stall);
            exp = {fa, fb, fls, ~stall, ~stall, Branch_ID & ~stall, stall};
            checks++;
            if (observed() !== exp) begin
                errors++;
                $display("FAIL random cycle %0d got %b want %b", i, observed(), exp);
            end
            advance();
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_alu_forward();
        test_load_use();
        test_store_data();
        test_branch_stall();
        test_x0();
        test_reset_mid_stall();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
